clock_ctrl: RTL

Run controller that sequences the processor clock by driving the `enable` input of the clock generator. It supports free-run, single-step, user halt, CPU-initiated halt and a programmable cycle budget. It counts executed (enabled) cycles and reports why execution stopped. It sits between the testbench/top-level control inputs and the clock module that clocks the CPU.

---
 rtl/clock_ctrl_pkg.sv | 35 +++
 rtl/clock_ctrl_if.sv | 46 ++++
 rtl/clock_ctrl_sat_counter.sv | 22 ++
 rtl/clock_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl shared types.
// State and stop-cause encodings plus stop priority.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP,
    STOPPED
  } ctrl_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_USER,
    CAUSE_CPU,
    CAUSE_LIMIT
  } stop_cause_t;

  // Priority: user halt > cpu halt > limit.
  function automatic stop_cause_t pick_cause(
    input logic halt,
    input logic cpu,
    input logic lim
  );
    if (halt)
      return CAUSE_USER;
    else if (cpu)
      return CAUSE_CPU;
    else if (lim)
      return CAUSE_LIMIT;
    else
      return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// clock_ctrl control/status bundle.
// master drives controls, slave is the controller.
interface clock_ctrl_if
  import clock_ctrl_pkg::*;
#(
  parameter int CYC_W = 32
);

  logic             start;
  logic             step;
  logic             halt_req;
  logic             cpu_halt;
  logic [CYC_W-1:0] cycle_limit;
  logic             enable;
  logic             running;
  logic             done;
  logic [CYC_W-1:0] cycle_count;
  stop_cause_t      stop_cause;

  modport master (
    output start,
    output step,
    output halt_req,
    output cpu_halt,
    output cycle_limit,
    input  enable,
    input  running,
    input  done,
    input  cycle_count,
    input  stop_cause
  );

  modport slave (
    input  start,
    input  step,
    input  halt_req,
    input  cpu_halt,
    input  cycle_limit,
    output enable,
    output running,
    output done,
    output cycle_count,
    output stop_cause
  );

endinterface

// File: rtl/clock_ctrl_sat_counter.sv
// Saturating up-counter, sync clear over increment.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc && (q != '1))
      q <= q + W'(1);
  end

endmodule

// File: rtl/clock_ctrl.sv
// Run controller sequencing the CPU clock enable.
// Free-run, single-step, halts and cycle budget.
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CYC_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  clock_ctrl_if.slave bus
);

  ctrl_state_t      state_q, state_d;
  stop_cause_t      cause_q, cause_d;
  stop_cause_t      hit;
  logic             en_q, en_d;
  logic             clr;
  logic             lim_hit;
  logic [CYC_W-1:0] cnt;

  // Wrapped cnt+1 at saturation is 0, so it never matches.
  assign lim_hit = (bus.cycle_limit != '0) &&
                   ((cnt + CYC_W'(1)) == bus.cycle_limit);

  assign hit = pick_cause(bus.halt_req,
                          bus.cpu_halt,
                          lim_hit);

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    en_d    = en_q;
    clr     = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.start) begin
          state_d = RUN;
          en_d    = 1'b1;
          cause_d = CAUSE_NONE;
          clr     = 1'b1;
        end else if (bus.step) begin
          state_d = STEP;
          en_d    = 1'b1;
        end
      end
      (state_q == RUN): begin
        if (hit != CAUSE_NONE) begin
          state_d = STOPPED;
          en_d    = 1'b0;
          cause_d = hit;
        end
      end
      (state_q == STEP): begin
        en_d = 1'b0;
        if (hit != CAUSE_NONE) begin
          state_d = STOPPED;
          cause_d = hit;
        end else begin
          state_d = IDLE;
        end
      end
      (state_q == STOPPED): begin
        if (bus.start) begin
          state_d = RUN;
          en_d    = 1'b1;
          cause_d = CAUSE_NONE;
          clr     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      en_q    <= en_d;
    end
  end

  sat_counter #(
    .W(CYC_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (en_q),
    .q    (cnt)
  );

  assign bus.enable      = en_q;
  assign bus.running     = (state_q == RUN) ||
                           (state_q == STEP);
  assign bus.done        = (state_q == STOPPED);
  assign bus.cycle_count = cnt;
  assign bus.stop_cause  = cause_q;

endmodule
